spi_nand_page_rd_ctrl: RTL
==========================

// Module: spi_nand_page_rd_ctrl
// PURPOSE
//  Host-side sequencer for single-die SPI NAND (x1, SPI mode 0). One start request runs
//  a full page fetch: PAGE READ (13h + 24b row), GET FEATURE C0h polling until OIP=0,
//  then READ FROM CACHE (03h + 16b col + 8 dummy) streaming bytes out over valid/ready.
//  Sits between bench/DMA logic and the SPI NAND model pins; sole SPI bus master.
// PARAMETERS
//  CLK_DIV    2     clk cycles per SCK half-period (>=1); bit time = 2*CLK_DIV clk
//  CS_GAP     4     min clk cycles CS_N held high between transactions (>=1)
//  MAX_POLL   1024  status polls allowed before timeout (>=1)
//  LEN_W      12    width of byte_cnt
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous reset, active high
//  start       in   1      1-cycle request; sampled only when busy=0
//  row_addr    in   24     page/row address for 13h
//  col_addr    in   16     cache column address for 03h
//  byte_cnt    in   LEN_W  bytes to read from cache; 0 = skip 03h phase
//  busy        out  1      high from cycle after accepted start until done
//  done        out  1      1-cycle pulse at end of sequence
//  err_timeout out  1      set with done if OIP never cleared; held until next start
//  rd_data     out  8      read byte, MSB = first bit on SO
//  rd_valid    out  1      rd_data valid; held until rd_ready
//  rd_ready    in   1      consumer accepts rd_data when rd_valid&rd_ready
//  spi_sck     out  1      SPI clock, idles low
//  spi_cs_n    out  1      chip select, idles high
//  spi_si      out  1      MOSI
//  spi_so      in   1      MISO
//  spi_wp_n    out  1      constant 1;  spi_hold_n  out 1  constant 1
// BEHAVIOUR
//  Reset (async): spi_cs_n=1, spi_sck=0, spi_si=0, busy=0, done=0, err_timeout=0,
//   rd_valid=0, rd_data=0, state=IDLE; mid-sequence reset aborts, CS_N rises at once.
//  All outputs registered. MSB first. Each bit: SCK low CLK_DIV cycles then high
//   CLK_DIV cycles; spi_si updated on first low cycle; spi_so sampled on last high cycle.
//  CS_N falls >=1 bit time before first SCK rise; rises one CLK_DIV after last SCK fall.
//  States: IDLE -> PR_CMD (32b out: 13h,row) -> GAP -> POLL (16b out 0Fh,C0h, 8b in)
//   -> GAP -> {POLL if status[0]=1 | RD (32b out 03h,col,00h; byte_cnt*8 in) | FIN}.
//  GAP: CS_N high exactly CS_GAP cycles, SCK low, then next state.
//  Poll counter cleared at start, +1 per completed POLL; if status[0]=1 and count
//   reaches MAX_POLL -> err_timeout=1, go FIN (no 03h issued).
//  byte_cnt=0 with OIP clear -> FIN straight after final POLL's GAP.
//  RD: after each 8 received bits, rd_data<=byte, rd_valid<=1. Before starting next
//   byte's first SCK rise, if rd_valid=1 and rd_ready=0: hold SCK low, CS_N low (stall).
//   rd_valid clears on handshake unless a new byte loads same cycle.
//  FIN: waits for last rd handshake, CS_N high, then done=1 one cycle, busy=0 next.
//  start while busy=1 ignored. row/col/byte_cnt latched on accepted start.
//  Status byte, ECC bits ignored except OIP (bit0).
// TESTING
//  1. row=0x000123, col=0, byte_cnt=4, model OIP clears after 2 polls, rd_ready=1 ->
//     SI shows 13 00 01 23, 0F C0 x3, 03 00 00 00; 4 bytes match model page; done=1,err=0.
//  2. MAX_POLL=3, OIP stuck 1 -> exactly 3 polls, no 03h, done with err_timeout=1.
//  3. byte_cnt=0 -> no 03h transaction; done after first clear poll.
//  4. byte_cnt=16, rd_ready toggling 1/0 every 5 cycles -> SCK stalls low at byte
//     boundaries, all 16 bytes delivered in order, no loss/duplication.
//  5. Assert rst during RD byte 3 -> CS_N=1 same cycle, rd_valid=0; new start succeeds.
//  6. start pulsed while busy -> ignored; CLK_DIV=1 -> SCK=clk/2, CS_GAP checked.

Source files
------------

// File: rtl/spi_nand_page_rd_ctrl.sv
// SPI NAND page read sequencer: PAGE READ, status poll, READ FROM CACHE.
// Single x1 mode-0 bus master; cache bytes leave over valid/ready.
module spi_nand_page_rd_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 4,
  parameter int MAX_POLL = 1024,
  parameter int LEN_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [23:0]      row_addr,
  input  logic [15:0]      col_addr,
  input  logic [LEN_W-1:0] byte_cnt,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             spi_sck,
  output logic             spi_cs_n,
  output logic             spi_si,
  input  logic             spi_so,
  output logic             spi_wp_n,
  output logic             spi_hold_n
);

  localparam int TW = $clog2(2*CLK_DIV + CS_GAP + 1);
  localparam int BW = LEN_W + 4;
  localparam int PW = $clog2(MAX_POLL + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LEAD_LAST = TW'(2*CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(CS_GAP - 1);
  localparam logic [PW-1:0] POLL_MAX  = PW'(MAX_POLL);

  typedef enum logic [2:0] {
    IDLE, PR_CMD, POLL, RD, GAP, FIN
  } state_t;

  typedef enum logic [1:0] {
    PH_LEAD, PH_LO, PH_HI, PH_TAIL
  } phase_t;

  state_t            state;
  state_t            gap_nxt;
  phase_t            ph;
  logic [TW-1:0]     tick;
  logic [BW-1:0]     bit_idx;
  logic [BW-1:0]     last_bit;
  logic [31:0]       tx_sr;
  logic [7:0]        rx_sr;
  logic [PW-1:0]     poll_cnt;
  logic [15:0]       col_q;
  logic [LEN_W-1:0]  cnt_q;

  logic              half_end;
  logic              rd_phase;
  logic              byte_end;
  logic              stall;
  logic [7:0]        rx_next;
  logic [PW-1:0]     poll_inc;

  assign half_end   = tick == HALF_LAST;
  assign rd_phase   = state == RD && bit_idx >= BW'(32);
  assign byte_end   = rd_phase && bit_idx[2:0] == 3'd7;
  assign stall      = rd_phase && bit_idx[2:0] == 3'd0
                      && rd_valid && !rd_ready;
  assign rx_next    = {rx_sr[6:0], spi_so};
  assign poll_inc   = poll_cnt + PW'(1);
  assign spi_wp_n   = 1'b1;
  assign spi_hold_n = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gap_nxt     <= IDLE;
      ph          <= PH_LEAD;
      tick        <= '0;
      bit_idx     <= '0;
      last_bit    <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      poll_cnt    <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      spi_sck     <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_si      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            poll_cnt    <= '0;
            col_q       <= col_addr;
            cnt_q       <= byte_cnt;
            tx_sr       <= {8'h13, row_addr};
            last_bit    <= BW'(31);
            bit_idx     <= '0;
            tick        <= '0;
            ph          <= PH_LEAD;
            spi_cs_n    <= 1'b0;
            state       <= PR_CMD;
          end
        end
        PR_CMD, POLL, RD: begin
          unique case (ph)
            PH_LEAD: begin
              if (tick == LEAD_LAST) begin
                tick   <= '0;
                ph     <= PH_LO;
                spi_si <= tx_sr[31];
                tx_sr  <= {tx_sr[30:0], 1'b0};
              end else begin
                tick <= tick + TW'(1);
              end
            end
            PH_LO: begin
              if (!half_end) begin
                tick <= tick + TW'(1);
              end else if (!stall) begin
                tick    <= '0;
                ph      <= PH_HI;
                spi_sck <= 1'b1;
              end
            end
            PH_HI: begin
              if (half_end) begin
                tick    <= '0;
                spi_sck <= 1'b0;
                rx_sr   <= rx_next;
                if (byte_end) begin
                  rd_data  <= rx_next;
                  rd_valid <= 1'b1;
                end
                if (bit_idx == last_bit) begin
                  ph     <= PH_TAIL;
                  spi_si <= 1'b0;
                end else begin
                  bit_idx <= bit_idx + BW'(1);
                  ph      <= PH_LO;
                  spi_si  <= tx_sr[31];
                  tx_sr   <= {tx_sr[30:0], 1'b0};
                end
              end else begin
                tick <= tick + TW'(1);
              end
            end
            PH_TAIL: begin
              if (half_end) begin
                tick     <= '0;
                spi_cs_n <= 1'b1;
                if (state == PR_CMD) begin
                  state   <= GAP;
                  gap_nxt <= POLL;
                end else if (state == POLL) begin
                  state    <= GAP;
                  poll_cnt <= poll_inc;
                  // rx_sr holds the full status byte; only OIP matters
                  if (rx_sr[0]) begin
                    if (poll_inc >= POLL_MAX) begin
                      err_timeout <= 1'b1;
                      gap_nxt     <= FIN;
                    end else begin
                      gap_nxt <= POLL;
                    end
                  end else begin
                    gap_nxt <= (cnt_q == '0) ? FIN : RD;
                  end
                end else begin
                  state <= FIN;
                end
              end else begin
                tick <= tick + TW'(1);
              end
            end
            default: ph <= PH_LEAD;
          endcase
        end
        GAP: begin
          if (tick == GAP_LAST) begin
            tick    <= '0;
            bit_idx <= '0;
            ph      <= PH_LEAD;
            state   <= gap_nxt;
            if (gap_nxt == POLL) begin
              spi_cs_n <= 1'b0;
              tx_sr    <= {8'h0F, 8'hC0, 16'h0000};
              last_bit <= BW'(23);
            end else if (gap_nxt == RD) begin
              spi_cs_n <= 1'b0;
              tx_sr    <= {8'h03, col_q, 8'h00};
              last_bit <= BW'({cnt_q, 3'b000}) + BW'(31);
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        FIN: begin
          if (!rd_valid) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
